// File: rtl/ahb_ri5cy_master.sv
// AHB-Lite initiator bridge: turns RI5CY req/gnt/rvalid requests into single,
// pipelined AHB-Lite transfers, including wait states and the two-cycle ERROR.
module ahb_ri5cy_master #(
    parameter int unsigned AHB_ADDR_WIDTH = 32,
    parameter int unsigned AHB_DATA_WIDTH = 32,
    parameter logic [3:0]  HPROT_VAL      = 4'b0011
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      req_i,
    output logic                      gnt_o,
    input  logic [AHB_ADDR_WIDTH-1:0] addr_i,
    input  logic                      we_i,
    input  logic [3:0]                be_i,
    input  logic [AHB_DATA_WIDTH-1:0] wdata_i,
    output logic                      rvalid_o,
    output logic [AHB_DATA_WIDTH-1:0] rdata_o,
    output logic                      err_o,
    output logic [AHB_ADDR_WIDTH-1:0] haddr_o,
    output logic                      hwrite_o,
    output logic [2:0]                hsize_o,
    output logic [2:0]                hburst_o,
    output logic [3:0]                hprot_o,
    output logic [1:0]                htrans_o,
    output logic                      hmastlock_o,
    output logic [AHB_DATA_WIDTH-1:0] hwdata_o,
    input  logic [AHB_DATA_WIDTH-1:0] hrdata_i,
    input  logic                      hready_i,
    input  logic                      hresp_i
);

    typedef enum logic [1:0] {IDLE, DATA, ERR2} state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_BYTE    = 3'b000;
    localparam logic [2:0] HSIZE_HALF    = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    state_e                    state_q, state_d;
    logic                      dp_we_q;
    logic [AHB_DATA_WIDTH-1:0] hwdata_q;
    logic [AHB_DATA_WIDTH-1:0] rdata_q;
    logic                      rvalid_q;
    logic                      err_q;

    logic                      dp_valid;
    logic                      addr_ok;
    logic                      gnt;
    logic                      complete;
    logic [1:0]                htrans;
    logic [2:0]                size;
    logic [1:0]                offset;
    logic                      unused_addr_lsbs;

    // The low address bits are rebuilt from the byte enables, not taken from the core.
    always_comb begin
        size   = HSIZE_WORD;
        offset = 2'b00;
        case (be_i)
            4'b1111: begin size = HSIZE_WORD; offset = 2'b00; end
            4'b0011: begin size = HSIZE_HALF; offset = 2'b00; end
            4'b1100: begin size = HSIZE_HALF; offset = 2'b10; end
            4'b0001: begin size = HSIZE_BYTE; offset = 2'b00; end
            4'b0010: begin size = HSIZE_BYTE; offset = 2'b01; end
            4'b0100: begin size = HSIZE_BYTE; offset = 2'b10; end
            4'b1000: begin size = HSIZE_BYTE; offset = 2'b11; end
            default: begin size = HSIZE_WORD; offset = 2'b00; end
        endcase
    end

    assign unused_addr_lsbs = ^addr_i[1:0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (gnt) state_d = DATA;
            end
            DATA: begin
                if (hready_i)     state_d = gnt ? DATA : IDLE;
                else if (hresp_i) state_d = ERR2;
            end
            ERR2: begin
                if (hready_i) state_d = gnt ? DATA : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ERR2 is not a data phase, so a new address may go out while ERROR completes.
    always_comb begin
        dp_valid = (state_q == DATA);
        addr_ok  = !(dp_valid && hresp_i);
        gnt      = req_i && addr_ok && hready_i;
        complete = (state_q != IDLE) && hready_i;
        htrans   = (req_i && addr_ok) ? HTRANS_NONSEQ : HTRANS_IDLE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dp_we_q  <= 1'b0;
            hwdata_q <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= complete;
            err_q    <= complete && hresp_i;
            if (gnt) begin
                dp_we_q  <= we_i;
                hwdata_q <= wdata_i;
            end
            if (complete && !dp_we_q && !hresp_i) begin
                rdata_q <= hrdata_i;
            end
        end
    end

    assign gnt_o       = gnt;
    assign htrans_o    = htrans;
    assign haddr_o     = {addr_i[AHB_ADDR_WIDTH-1:2], offset};
    assign hwrite_o    = we_i;
    assign hsize_o     = size;
    assign hburst_o    = 3'b000;
    assign hprot_o     = HPROT_VAL;
    assign hmastlock_o = 1'b0;
    assign hwdata_o    = hwdata_q;
    assign rvalid_o    = rvalid_q;
    assign rdata_o     = rdata_q;
    assign err_o       = err_q;

endmodule
